mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32: address width of all address ports.
REQ-002 Parameter DW, default 32: data width of all data ports.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mN_req  input  1  requester N (N=0 core, N=1 loader/debug) access request; held until mN_gnt.
REQ-006 mN_we  input  1  requester N write enable (1 write, 0 read).
REQ-007 mN_addr  input  AW  requester N byte address.
REQ-008 mN_wdata  input  DW  requester N write data.
REQ-009 mN_gnt  output  1  one-cycle pulse; request accepted and latched.
REQ-010 mN_rvalid  output  1  one-cycle pulse; access complete (read data valid, or write done).
REQ-011 mN_rdata  output  DW  read data, valid only while mN_rvalid=1.
REQ-012 mem_en  output  1  memory access strobe.
REQ-013 mem_we  output  1  memory write enable; qualified by mem_en.
REQ-014 mem_addr  output  AW  memory address.
REQ-015 mem_wdata  output  DW  memory write data.
REQ-016 mem_rdata  input  DW  synchronous-read memory data, valid the cycle after mem_en=1.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, RESP.
- IDLE: if any mN_req=1, arbitrate, assert winner's mN_gnt for that cycle, latch we/addr/wdata and owner ID, go to ACCESS; else stay.
- ACCESS: mem_en=1, mem_we/addr/wdata from latched values; go to RESP unconditionally.
- RESP: owner's mN_rvalid=1, mN_rdata=mem_rdata (reads; writes drive 0); go to IDLE.
REQ-019 Latency: gnt at cycle T, mem_en at T+1, rvalid at T+2; next gnt no earlier than T+3.
REQ-020 Exactly one mN_gnt SHALL be high per cycle at most; never outside IDLE.
REQ-021 Arbitration (default) SHALL be round-robin: on simultaneous requests, the port not granted last wins; last_grant resets to 1 so port 0 wins first contention.
REQ-022 A single requester SHALL win regardless of last_grant; last_grant updates on every gnt.
REQ-023 Requester inputs SHALL be ignored outside IDLE; changes after gnt SHALL not affect the in-flight access.
REQ-024 Dropping mN_req before gnt SHALL withdraw the request with no side effect.
REQ-025 mem_en, mem_we SHALL be 0 in IDLE and RESP; mem_addr/mem_wdata SHALL hold latched values in all states.
REQ-026 mN_rvalid SHALL only pulse for the port that received the corresponding gnt.

Reset
REQ-027 reset=0 SHALL immediately force state=IDLE, last_grant=1, latched registers=0, all outputs 0.
REQ-028 Reset asserted in ACCESS or RESP SHALL abort the access: no rvalid issued, mem_en drops asynchronously.
REQ-029 After reset deassertion, first gnt SHALL occur no earlier than the first rising edge with reset=1 and a request present.

Configuration
REQ-030 Macro MEM_ARB_FIXED_PRIO_EN: when defined, port 0 SHALL win every contention (fixed priority) and last_grant is unused; when undefined, REQ-021 round-robin applies. All other behaviour identical.

Verification
REQ-031 Single read: m0_req=1, we=0, addr=0x0000_0010, memory word 0xDEADBEEF -> m0_gnt at T, mem_en/mem_addr=0x10 at T+1, m0_rvalid with m0_rdata=0xDEADBEEF at T+2.
REQ-032 Single write: m1_req=1, we=1, addr=0x20, wdata=0x1234_5678 -> mem_en=1, mem_we=1, mem_addr=0x20, mem_wdata=0x12345678 at T+1; m1_rvalid at T+2, m0 outputs stay 0.
REQ-033 Contention, round-robin: both req held for 4 grants -> grant order 0,1,0,1, gnts 3 cycles apart; with MEM_ARB_FIXED_PRIO_EN -> 0,0,0,0 while m0_req held.
REQ-034 Hold-off: m1_req asserted during port 0 ACCESS with addr 0x40 -> m1_gnt only in next IDLE cycle; in-flight port 0 access unchanged when m0_addr changes after gnt.
REQ-035 Reset mid-access: reset=0 asynchronously during ACCESS -> mem_en=0, busy=0 immediately, no rvalid; after release, pending m0 read of 0x10 completes normally in 3 cycles.
REQ-036 Withdrawn request: m1_req pulsed 1 cycle while busy, then 0 -> no m1_gnt, no memory access for port 1.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: IDLE -> ACCESS -> RESP per transaction, round-robin by default.
// Define MEM_ARB_FIXED_PRIO_EN to make port 0 win every contention.
module mem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic          last_grant_q, last_grant_d;
`endif

  logic req_any;
  logic winner;
  logic grant;

  // Grant is combinational in IDLE, so it is masked while reset is held low.
  always_comb begin
    req_any = (m0_req | m1_req) & reset;
`ifdef MEM_ARB_FIXED_PRIO_EN
    winner  = ~m0_req;
`else
    winner  = (m0_req & m1_req) ? ~last_grant_q : m1_req;
`endif
    grant   = (state_q == IDLE) & req_any;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant) begin
          owner_d      = winner;
          we_d         = winner ? m1_we    : m0_we;
          addr_d       = winner ? m1_addr  : m0_addr;
          wdata_d      = winner ? m1_wdata : m0_wdata;
`ifndef MEM_ARB_FIXED_PRIO_EN
          last_grant_d = winner;
`endif
          state_d      = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  always_comb begin
    m0_gnt    = grant & ~winner;
    m1_gnt    = grant &  winner;
    mem_en    = (state_q == ACCESS);
    mem_we    = (state_q == ACCESS) & we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    m0_rvalid = (state_q == RESP) & ~owner_q;
    m1_rvalid = (state_q == RESP) &  owner_q;
    m0_rdata  = (m0_rvalid & ~we_q) ? mem_rdata : '0;
    m1_rdata  = (m1_rvalid & ~we_q) ? mem_rdata : '0;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous-read memory model.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] <= '0;
    mem[4]  <= 32'hDEADBEEF;
    mem[16] <= 32'hCAFEF00D;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[7:2]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  logic e_g0, e_g1, e_rv0, e_rv1;

  initial begin
    reset = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_gnt", {m0_gnt, m1_gnt}, 0);
    check("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    repeat (2) tick();
    reset = 1'b1;

    // single read, port 0
    tick(); m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    settle();
    check("rd_g0", m0_gnt, 1); check("rd_g1", m1_gnt, 0); check("rd_busy0", busy, 0);
    tick(); m0_req = 0; m0_addr = 32'hFC;
    settle();
    check("rd_en", mem_en, 1); check("rd_we", mem_we, 0);
    check("rd_addr", mem_addr, 32'h10); check("rd_busy1", busy, 1); check("rd_g0_off", m0_gnt, 0);
    tick(); settle();
    check("rd_rv0", m0_rvalid, 1); check("rd_data", m0_rdata, 32'hDEADBEEF);
    check("rd_rv1", m1_rvalid, 0); check("rd_en_resp", mem_en, 0);
    tick(); settle();
    check("rd_idle", busy, 0); check("rd_rv0_off", m0_rvalid, 0);

    // single write, port 1
    tick(); m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
    settle();
    check("wr_g1", m1_gnt, 1); check("wr_g0", m0_gnt, 0);
    tick(); m1_req = 0; m1_we = 0; m1_wdata = '0;
    settle();
    check("wr_en", mem_en, 1); check("wr_we", mem_we, 1);
    check("wr_addr", mem_addr, 32'h20); check("wr_wdata", mem_wdata, 32'h12345678);
    check("wr_m0_quiet", {m0_gnt, m0_rvalid, m0_rdata}, 0);
    tick(); settle();
    check("wr_rv1", m1_rvalid, 1); check("wr_rdata0", m1_rdata, 0);
    check("wr_m0_rv", {m0_rvalid, m0_rdata}, 0); check("wr_we_resp", mem_we, 0);

    // contention, both held
    tick();
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    m1_req = 1; m1_we = 0; m1_addr = 32'h20;
    for (int k = 0; k < 12; k++) begin
      settle();
`ifdef MEM_ARB_FIXED_PRIO_EN
      e_g0 = (k % 3 == 0); e_g1 = 0; e_rv0 = (k % 3 == 2); e_rv1 = 0;
`else
      e_g0 = (k % 6 == 0); e_g1 = (k % 6 == 3); e_rv0 = (k % 6 == 2); e_rv1 = (k % 6 == 5);
`endif
      check($sformatf("cont_g0_%0d", k), m0_gnt, e_g0);
      check($sformatf("cont_g1_%0d", k), m1_gnt, e_g1);
      check($sformatf("cont_rv0_%0d", k), m0_rvalid, e_rv0);
      check($sformatf("cont_rv1_%0d", k), m1_rvalid, e_rv1);
      check($sformatf("cont_rd0_%0d", k), m0_rdata, e_rv0 ? 32'hDEADBEEF : 32'h0);
      check($sformatf("cont_rd1_%0d", k), m1_rdata, e_rv1 ? 32'h12345678 : 32'h0);
      tick();
    end
    m0_req = 0; m1_req = 0;
    settle();
    check("cont_end_idle", busy, 0);

    // hold-off: port 1 requests during port 0 access
    tick(); m0_req = 1; m0_addr = 32'h10;
    settle();
    check("ho_g0", m0_gnt, 1);
    tick(); m0_req = 0; m0_addr = 32'h44; m1_req = 1; m1_we = 0; m1_addr = 32'h40;
    settle();
    check("ho_g1_acc", m1_gnt, 0); check("ho_addr", mem_addr, 32'h10); check("ho_en", mem_en, 1);
    tick(); settle();
    check("ho_g1_resp", m1_gnt, 0); check("ho_rv0", m0_rvalid, 1);
    check("ho_rd0", m0_rdata, 32'hDEADBEEF); check("ho_rv1", m1_rvalid, 0);
    tick(); settle();
    check("ho_g1_idle", m1_gnt, 1); check("ho_busy", busy, 0);
    tick(); m1_req = 0;
    settle();
    check("ho_addr1", mem_addr, 32'h40); check("ho_en1", mem_en, 1);
    tick(); settle();
    check("ho_rv1_end", m1_rvalid, 1); check("ho_rd1", m1_rdata, 32'hCAFEF00D);

    // reset during ACCESS, both requesters pending
    tick(); m0_req = 1; m0_addr = 32'h10;
    settle();
    check("rm_g0", m0_gnt, 1);
    tick(); m1_req = 1; m1_addr = 32'h40;
    settle();
    check("rm_en", mem_en, 1);
    #2 reset = 1'b0;
    #1;
    check("rm_en_drop", mem_en, 0); check("rm_busy_drop", busy, 0);
    check("rm_gnt_masked", {m0_gnt, m1_gnt}, 0); check("rm_addr_clr", mem_addr, 0);
    tick(); settle();
    check("rm_no_rv", {m0_rvalid, m1_rvalid}, 0); check("rm_busy_held", busy, 0);
    #1 reset = 1'b1;
    #1;
    check("rm_first_g0", m0_gnt, 1); check("rm_first_g1", m1_gnt, 0);
    tick(); m0_req = 0;
    settle();
    check("rm_en2", mem_en, 1); check("rm_addr2", mem_addr, 32'h10); check("rm_g1_acc", m1_gnt, 0);
    tick(); settle();
    check("rm_rv0", m0_rvalid, 1); check("rm_rd0", m0_rdata, 32'hDEADBEEF);
    tick(); settle();
    check("rm_g1", m1_gnt, 1);
    tick(); m1_req = 0;
    settle();
    check("rm_addr3", mem_addr, 32'h40);
    tick(); settle();
    check("rm_rv1", m1_rvalid, 1); check("rm_rd1", m1_rdata, 32'hCAFEF00D);

    // withdrawn request from port 1 while busy
    tick(); m0_req = 1; m0_addr = 32'h10;
    settle();
    check("wd_g0", m0_gnt, 1);
    tick(); m0_req = 0; m1_req = 1; m1_addr = 32'h48;
    settle();
    check("wd_g1_a", m1_gnt, 0);
    tick(); m1_req = 0;
    settle();
    check("wd_g1_b", m1_gnt, 0); check("wd_rv0", m0_rvalid, 1);
    tick(); settle();
    check("wd_g1_c", m1_gnt, 0); check("wd_idle", busy, 0);
    tick(); settle();
    check("wd_no_mem", mem_en, 0); check("wd_no_rv1", m1_rvalid, 0); check("wd_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
